rf_fwd_stage: RTL and testbench

//  SPU register-fetch/forward stage. Sits directly upstream of the execution units (SimpleFixed2 etc.).

---
 rtl/rf_fwd_stage_pkg.sv | 30 +++
 rtl/rf_fwd_stage_if.sv | 53 +++++
 rtl/rf_fwd_stage_regfile.sv | 37 +++
 rtl/rf_fwd_stage.sv | 112 +++++++++++
 tb/tb_rf_fwd_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rf_fwd_stage_pkg.sv
// Shared types and constants for the SPU register-fetch/forward stage.
package rf_fwd_stage_pkg;

  localparam int NUM_REGS = 128;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 7;
  localparam int NUM_FWD  = 6;
  localparam int OPC_W    = 11;
  localparam int FMT_W    = 3;
  localparam int IMM_W    = 18;

  // Bit 0 is the MSB throughout, matching the SPU ISA numbering.
  typedef logic [0:ADDR_W-1] reg_addr_t;
  typedef logic [0:DATA_W-1] quad_t;
  typedef logic [0:OPC_W-1]  opcode_t;
  typedef logic [0:FMT_W-1]  fmt_t;
  typedef logic [0:IMM_W-1]  imm_t;

  localparam opcode_t OP_NOP = '0;

  // Control bundle carried to execute alongside the operands.
  typedef struct packed {
    opcode_t   op;
    fmt_t      format;
    reg_addr_t rt_addr;
    imm_t      imm;
    logic      reg_write;
  } ctl_t;

endpackage

// File: rtl/rf_fwd_stage_if.sv
// Decode, writeback, forwarding and execute-side signals of the stage.
interface rf_fwd_stage_if;
  import rf_fwd_stage_pkg::*;

  // decode side
  opcode_t   op_dec;
  fmt_t      format_dec;
  reg_addr_t ra_addr;
  reg_addr_t rb_addr;
  reg_addr_t rc_addr;
  reg_addr_t rt_addr_dec;
  imm_t      imm_dec;
  logic      reg_write_dec;
  logic      stall;
  logic      flush;
  // writeback ports
  logic      wr_en_e;
  reg_addr_t wr_addr_e;
  quad_t     wr_data_e;
  logic      wr_en_o;
  reg_addr_t wr_addr_o;
  quad_t     wr_data_o;
  // forwarding network, source 0 at the MSB end
  logic [0:NUM_FWD-1]        fwd_valid;
  logic [0:NUM_FWD*ADDR_W-1] fwd_addr;
  logic [0:NUM_FWD*DATA_W-1] fwd_data;
  // execute side
  opcode_t   op;
  fmt_t      format;
  reg_addr_t rt_addr;
  quad_t     ra;
  quad_t     rb;
  quad_t     rc;
  imm_t      imm;
  logic      reg_write;

  modport master (
    output op_dec, format_dec, ra_addr, rb_addr, rc_addr, rt_addr_dec, imm_dec,
           reg_write_dec, stall, flush,
           wr_en_e, wr_addr_e, wr_data_e, wr_en_o, wr_addr_o, wr_data_o,
           fwd_valid, fwd_addr, fwd_data,
    input  op, format, rt_addr, ra, rb, rc, imm, reg_write
  );

  modport slave (
    input  op_dec, format_dec, ra_addr, rb_addr, rc_addr, rt_addr_dec, imm_dec,
           reg_write_dec, stall, flush,
           wr_en_e, wr_addr_e, wr_data_e, wr_en_o, wr_addr_o, wr_data_o,
           fwd_valid, fwd_addr, fwd_data,
    output op, format, rt_addr, ra, rb, rc, imm, reg_write
  );

endinterface

// File: rtl/rf_fwd_stage_regfile.sv
// 128x128 register file: three async read ports, even/odd sync write ports.
module rf_fwd_stage_regfile
  import rf_fwd_stage_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we_e,
  input  reg_addr_t wa_e,
  input  quad_t     wd_e,
  input  logic      we_o,
  input  reg_addr_t wa_o,
  input  quad_t     wd_o,
  input  reg_addr_t ad_a,
  input  reg_addr_t ad_b,
  input  reg_addr_t ad_c,
  output quad_t     rd_a,
  output quad_t     rd_b,
  output quad_t     rd_c
);

  quad_t mem [NUM_REGS];

  // Clear on reset; even write is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      if (we_o) mem[wa_o] <= wd_o;
      if (we_e) mem[wa_e] <= wd_e;
    end
  end

  assign rd_a = mem[ad_a];
  assign rd_b = mem[ad_b];
  assign rd_c = mem[ad_c];

endmodule

// File: rtl/rf_fwd_stage.sv
// SPU register-fetch/forward stage: resolves ra/rb/rc against the forwarding
// network, the writeback ports and the register file, then registers them
// together with decoded control for the execute stage.
module rf_fwd_stage
  import rf_fwd_stage_pkg::*;
(
  input logic          clk,
  input logic          reset,
  rf_fwd_stage_if.slave bus
);

  reg_addr_t ra_h, rb_h, rc_h;   // source addresses of the instruction in execute
  reg_addr_t src_a, src_b, src_c;
  quad_t     arr_a, arr_b, arr_c;
  quad_t     opnd_a, opnd_b, opnd_c;
  quad_t     ra_q, rb_q, rc_q;
  ctl_t      ctl_q, ctl_d;

  // A stalled instruction keeps re-reading its own sources so late results land.
  assign src_a = bus.stall ? ra_h : bus.ra_addr;
  assign src_b = bus.stall ? rb_h : bus.rb_addr;
  assign src_c = bus.stall ? rc_h : bus.rc_addr;

  rf_fwd_stage_regfile u_rf (
    .clk  (clk),
    .reset(reset),
    .we_e (bus.wr_en_e),
    .wa_e (bus.wr_addr_e),
    .wd_e (bus.wr_data_e),
    .we_o (bus.wr_en_o),
    .wa_o (bus.wr_addr_o),
    .wd_o (bus.wr_data_o),
    .ad_a (src_a),
    .ad_b (src_b),
    .ad_c (src_c),
    .rd_a (arr_a),
    .rd_b (arr_b),
    .rd_c (arr_c)
  );

  // Lowest priority first so later assignments override: array, odd WB,
  // even WB, then forwarding sources from oldest down to youngest (index 0).
  function automatic quad_t sel_opnd(
    input reg_addr_t                 src,
    input quad_t                     arr,
    input logic [0:NUM_FWD-1]        fv,
    input logic [0:NUM_FWD*ADDR_W-1] fa,
    input logic [0:NUM_FWD*DATA_W-1] fd,
    input logic                      we_e,
    input reg_addr_t                 wa_e,
    input quad_t                     wd_e,
    input logic                      we_o,
    input reg_addr_t                 wa_o,
    input quad_t                     wd_o
  );
    quad_t r;
    r = arr;
    if (we_o && wa_o == src) r = wd_o;
    if (we_e && wa_e == src) r = wd_e;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fv[i] && fa[i*ADDR_W +: ADDR_W] == src) r = fd[i*DATA_W +: DATA_W];
    return r;
  endfunction

  assign opnd_a = sel_opnd(src_a, arr_a, bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                           bus.wr_en_e, bus.wr_addr_e, bus.wr_data_e,
                           bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
  assign opnd_b = sel_opnd(src_b, arr_b, bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                           bus.wr_en_e, bus.wr_addr_e, bus.wr_data_e,
                           bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);
  assign opnd_c = sel_opnd(src_c, arr_c, bus.fwd_valid, bus.fwd_addr, bus.fwd_data,
                           bus.wr_en_e, bus.wr_addr_e, bus.wr_data_e,
                           bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o);

  assign ctl_d = '{op: bus.op_dec, format: bus.format_dec, rt_addr: bus.rt_addr_dec,
                   imm: bus.imm_dec, reg_write: bus.reg_write_dec};

  // Output register: reset > flush > stall (operands only) > normal issue.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      ctl_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
      ra_h  <= '0;
      rb_h  <= '0;
      rc_h  <= '0;
    end else if (bus.stall) begin
      ra_q  <= opnd_a;
      rb_q  <= opnd_b;
      rc_q  <= opnd_c;
    end else begin
      ctl_q <= ctl_d;
      ra_q  <= opnd_a;
      rb_q  <= opnd_b;
      rc_q  <= opnd_c;
      ra_h  <= bus.ra_addr;
      rb_h  <= bus.rb_addr;
      rc_h  <= bus.rc_addr;
    end
  end

  assign bus.op        = ctl_q.op;
  assign bus.format    = ctl_q.format;
  assign bus.rt_addr   = ctl_q.rt_addr;
  assign bus.imm       = ctl_q.imm;
  assign bus.reg_write = ctl_q.reg_write;
  assign bus.ra        = ra_q;
  assign bus.rb        = rb_q;
  assign bus.rc        = rc_q;

endmodule

// File: tb/tb_rf_fwd_stage.sv
// Directed bench for rf_fwd_stage: reset, WB write/read, bypass, forwarding
// priority, stall re-resolution, flush and reset-during-stall.
module tb_rf_fwd_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  rf_fwd_stage_if bus();

  rf_fwd_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Both WB ports hitting one register in the same cycle is an illegal program.
  always @(posedge clk)
    if (!reset)
      assert (!(bus.wr_en_e && bus.wr_en_o && bus.wr_addr_e == bus.wr_addr_o))
        else $error("illegal dual WB write to r%0d", bus.wr_addr_e);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] ONES16 = {8{16'h0001}};
  localparam logic [127:0] AAAA   = {8{16'hAAAA}};
  localparam logic [127:0] FIVES  = {8{16'h5555}};
  localparam logic [127:0] FFFF   = {8{16'hFFFF}};

  initial begin
    bus.op_dec = '0;  bus.format_dec = '0; bus.ra_addr = '0; bus.rb_addr = '0;
    bus.rc_addr = '0; bus.rt_addr_dec = '0; bus.imm_dec = '0; bus.reg_write_dec = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.wr_en_e = 1'b0; bus.wr_addr_e = '0; bus.wr_data_e = '0;
    bus.wr_en_o = 1'b0; bus.wr_addr_o = '0; bus.wr_data_o = '0;
    bus.fwd_valid = '0; bus.fwd_addr = '0; bus.fwd_data = '0;

    // 1. reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_op", bus.op, 0);
    check("rst_rw", bus.reg_write, 0);
    check("rst_ra", bus.ra, 0);
    check("rst_imm", bus.imm, 0);
    bus.op_dec = 11'h001; bus.ra_addr = 7'd5; bus.format_dec = 3'd2;
    bus.rt_addr_dec = 7'd9; bus.imm_dec = 18'h2ABCD; bus.reg_write_dec = 1'b1;
    step();
    check("r5_zero", bus.ra, 0);
    check("issue_op", bus.op, 11'h001);
    check("issue_fmt", bus.format, 3'd2);
    check("issue_rt", bus.rt_addr, 7'd9);
    check("issue_imm", bus.imm, 18'h2ABCD);
    check("issue_rw", bus.reg_write, 1);

    // 2. WB write r3, read next cycle from the array
    bus.wr_en_e = 1'b1; bus.wr_addr_e = 7'd3; bus.wr_data_e = ONES16; bus.ra_addr = 7'd0;
    step();
    bus.wr_en_e = 1'b0; bus.ra_addr = 7'd3;
    step();
    check("rf_read_r3", bus.ra, ONES16);

    // 3. same-cycle bypass, even to rb and odd to rc
    bus.wr_en_e = 1'b1; bus.wr_addr_e = 7'd7; bus.wr_data_e = AAAA;
    bus.wr_en_o = 1'b1; bus.wr_addr_o = 7'd8; bus.wr_data_o = FIVES;
    bus.rb_addr = 7'd7; bus.rc_addr = 7'd8;
    step();
    check("byp_even_rb", bus.rb, AAAA);
    check("byp_odd_rc", bus.rc, FIVES);
    bus.wr_en_e = 1'b0; bus.wr_en_o = 1'b0;
    step();
    check("rf_r7", bus.rb, AAAA);
    check("rf_r8", bus.rc, FIVES);

    // 4. forwarding priority over array: r4 = 3 in array
    bus.wr_en_e = 1'b1; bus.wr_addr_e = 7'd4; bus.wr_data_e = 128'h3;
    step();
    bus.wr_en_e = 1'b0; bus.ra_addr = 7'd4;
    bus.fwd_valid = 6'b101000;
    bus.fwd_addr  = {7'd4, 7'd0, 7'd4, 21'd0};
    bus.fwd_data  = {128'h1, 128'h0, 128'h2, 384'h0};
    step();
    check("fwd0_wins", bus.ra, 128'h1);
    bus.fwd_valid = 6'b001000;
    step();
    check("fwd2_only", bus.ra, 128'h2);
    bus.fwd_valid = '0;
    step();
    check("array_r4", bus.ra, 128'h3);
    // forwarding beats same-cycle WB
    bus.ra_addr = 7'd10; bus.wr_en_e = 1'b1; bus.wr_addr_e = 7'd10; bus.wr_data_e = 128'h77;
    bus.fwd_valid = 6'b000001; bus.fwd_addr = {35'd0, 7'd10}; bus.fwd_data = {640'h0, 128'h99};
    step();
    check("fwd_over_wb", bus.ra, 128'h99);
    bus.fwd_valid = '0; bus.wr_en_e = 1'b0;

    // 5. stall with held source r9; fwd1 supplies it in stall cycle 2
    bus.op_dec = 11'h123; bus.reg_write_dec = 1'b1; bus.ra_addr = 7'd9;
    step();
    check("st_issue_op", bus.op, 11'h123);
    check("st_issue_ra", bus.ra, 0);
    bus.stall = 1'b1; bus.op_dec = 11'h055; bus.reg_write_dec = 1'b0; bus.ra_addr = 7'd20;
    step();
    check("st1_op", bus.op, 11'h123);
    check("st1_ra", bus.ra, 0);
    bus.fwd_valid = 6'b010000; bus.fwd_addr = {7'd0, 7'd9, 28'd0};
    bus.fwd_data = {128'h0, FFFF, 512'h0};
    step();
    check("st2_op", bus.op, 11'h123);
    check("st2_ra", bus.ra, FFFF);
    bus.fwd_valid = '0; bus.wr_en_e = 1'b1; bus.wr_addr_e = 7'd9; bus.wr_data_e = FFFF;
    step();
    check("st3_op", bus.op, 11'h123);
    check("st3_rw", bus.reg_write, 1);
    check("st3_ra", bus.ra, FFFF);
    bus.wr_en_e = 1'b0; bus.stall = 1'b0;
    step();
    check("unstall_op", bus.op, 11'h055);
    check("unstall_ra", bus.ra, 0);

    // 6. flush with stall
    bus.op_dec = 11'b00001011111; bus.reg_write_dec = 1'b1; bus.rt_addr_dec = 7'd5;
    bus.imm_dec = 18'h00123; bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    check("flush_op", bus.op, 0);
    check("flush_rw", bus.reg_write, 0);
    check("flush_rt", bus.rt_addr, 0);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.ra_addr = 7'd3;
    step();
    check("post_flush_op", bus.op, 11'h05F);
    check("post_flush_ra", bus.ra, ONES16);
    bus.stall = 1'b1; bus.op_dec = 11'h001;
    step();
    check("hold_op", bus.op, 11'h05F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_stall_op", bus.op, 0);
    check("rst_stall_rw", bus.reg_write, 0);
    check("rst_stall_ra", bus.ra, 0);
    check("rst_stall_rt", bus.rt_addr, 0);
    bus.stall = 1'b0; bus.ra_addr = 7'd3; bus.rb_addr = 7'd7;
    step();
    check("cleared_r3", bus.ra, 0);
    check("cleared_r7", bus.rb, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
